// File: rtl/ext_mem_bridge.sv
// Core-to-Arduino memory bridge: serialises each request into address/data beats
// on a narrow bus, with per-beat read acknowledge, read timeout and a local UART window.
module ext_mem_bridge #(
  parameter int unsigned         ADDR_W         = 16,
  parameter int unsigned         DATA_W         = 16,
  parameter int unsigned         BUS_W          = 8,
  parameter int unsigned         WAIT_CYCLES    = 4,
  parameter int unsigned         TIMEOUT        = 255,
  parameter logic [ADDR_W-1:0]   UART_RX_ADDR   = 16'h7FA0,
  parameter logic [ADDR_W-1:0]   UART_TX_ADDR   = 16'h7FA1,
  parameter logic [ADDR_W-1:0]   UART_STAT_ADDR = 16'h7FA2,
  localparam int unsigned        AB             = ADDR_W / BUS_W,
  localparam int unsigned        DB             = DATA_W / BUS_W,
  localparam int unsigned        SB             = (AB > DB) ? AB : DB
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic              ext_we,
  output logic              ext_re,
  output logic              ext_reg_en,
  output logic [SB-1:0]     ext_sel,
  output logic              ext_oe,
  output logic [BUS_W-1:0]  ext_dout,
  input  logic [BUS_W-1:0]  ext_din,
  input  logic              ext_ack,
  input  logic              uart_rx_valid,
  input  logic [7:0]        uart_rx_data,
  input  logic              uart_busy,
  output logic              uart_send,
  output logic [7:0]        uart_tx_data
);

  localparam int unsigned BW = (SB > 1) ? $clog2(SB) : 1;
  localparam int unsigned HW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, RDATA, UART_OP, DONE} state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              err_q, err_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [7:0]        tmo_q, tmo_d;
  logic              ack_seen_q, ack_seen_d;
  logic [7:0]        rx_byte_q, rx_byte_d;
  logic              rx_full_q, rx_full_d;
  logic              rx_ovf_q, rx_ovf_d;
  logic              rx_clr;
  logic              hold_done;
  int unsigned       beat_lsb;

  function automatic logic is_uart(input logic [ADDR_W-1:0] a);
    return (a == UART_RX_ADDR) || (a == UART_TX_ADDR) || (a == UART_STAT_ADDR);
  endfunction

  assign hold_done = (hold_q == HW'(WAIT_CYCLES));
  assign beat_lsb  = 32'(beat_q) * BUS_W;
  assign rsp_rdata = rsp_rdata_q;

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    beat_d       = beat_q;
    hold_d       = hold_q;
    tmo_d        = tmo_q;
    ack_seen_d   = ack_seen_q;
    rx_byte_d    = rx_byte_q;
    rx_full_d    = rx_full_q;
    rx_ovf_d     = rx_ovf_q;
    rx_clr       = 1'b0;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    rsp_error    = 1'b0;
    ext_we       = 1'b0;
    ext_re       = 1'b0;
    ext_reg_en   = 1'b0;
    ext_sel      = '0;
    ext_oe       = 1'b0;
    ext_dout     = '0;
    uart_send    = 1'b0;
    uart_tx_data = '0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d       = req_we;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          rdata_d    = '0;
          err_d      = 1'b0;
          beat_d     = '0;
          hold_d     = '0;
          tmo_d      = '0;
          ack_seen_d = 1'b0;
          state_d    = is_uart(req_addr) ? UART_OP : ADDR;
        end
      end
      ADDR: begin
        ext_we     = we_q;
        ext_re     = !we_q;
        ext_reg_en = 1'b1;
        ext_oe     = 1'b1;
        ext_sel    = SB'(1) << beat_q;
        ext_dout   = addr_q[beat_lsb +: BUS_W];
        if (hold_done) begin
          hold_d = '0;
          if (beat_q == BW'(AB - 1)) begin
            beat_d  = '0;
            state_d = we_q ? WDATA : RDATA;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      WDATA: begin
        ext_we   = 1'b1;
        ext_oe   = 1'b1;
        ext_sel  = SB'(1) << beat_q;
        ext_dout = wdata_q[beat_lsb +: BUS_W];
        if (hold_done) begin
          hold_d = '0;
          if (beat_q == BW'(DB - 1)) begin
            beat_d  = '0;
            state_d = DONE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      RDATA: begin
        ext_re     = 1'b1;
        ext_sel    = SB'(1) << beat_q;
        // Capture only on a fresh ack edge; a held ack must drop before the next beat.
        ack_seen_d = ext_ack;
        if (ext_ack && !ack_seen_q) begin
          rdata_d[beat_lsb +: BUS_W] = ext_din;
          tmo_d = '0;
          if (beat_q == BW'(DB - 1)) begin
            beat_d  = '0;
            state_d = DONE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end else if (tmo_q == 8'(TIMEOUT - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      UART_OP: begin
        state_d = DONE;
        if (!we_q && addr_q == UART_RX_ADDR) begin
          rdata_d = DATA_W'(rx_byte_q);
          rx_clr  = 1'b1;
        end else if (!we_q && addr_q == UART_STAT_ADDR) begin
          rdata_d = DATA_W'({rx_ovf_q, rx_full_q, uart_busy});
        end else if (we_q && addr_q == UART_TX_ADDR) begin
          if (uart_busy) begin
            state_d = UART_OP;
          end else begin
            uart_send    = 1'b1;
            uart_tx_data = wdata_q[7:0];
          end
        end
      end
      DONE: begin
        rsp_valid = 1'b1;
        rsp_error = err_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // RX strobe takes priority over a same-cycle read clear; the reader still gets the old byte.
    if (rx_clr) begin
      rx_full_d = 1'b0;
      rx_ovf_d  = 1'b0;
    end
    if (uart_rx_valid) begin
      rx_byte_d = uart_rx_data;
      rx_full_d = 1'b1;
      if (rx_full_q && !rx_clr) rx_ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rsp_rdata_q <= '0;
      err_q       <= 1'b0;
      beat_q      <= '0;
      hold_q      <= '0;
      tmo_q       <= '0;
      ack_seen_q  <= 1'b0;
      rx_byte_q   <= '0;
      rx_full_q   <= 1'b0;
      rx_ovf_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      beat_q     <= beat_d;
      hold_q     <= hold_d;
      tmo_q      <= tmo_d;
      ack_seen_q <= ack_seen_d;
      rx_byte_q  <= rx_byte_d;
      rx_full_q  <= rx_full_d;
      rx_ovf_q   <= rx_ovf_d;
      if (state_d == DONE) rsp_rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_ext_mem_bridge.sv
// Self-checking bench for ext_mem_bridge: table-driven requests with a response
// scoreboard, an Arduino read responder, and hand-written UART/timeout/reset sequences.
module tb_ext_mem_bridge;

  localparam int unsigned AB    = 2;
  localparam int unsigned DB    = 2;
  localparam int unsigned WAITC = 4;
  localparam int unsigned TMO   = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we, req_ready;
  logic [15:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_error;
  logic [15:0] rsp_rdata;
  logic        ext_we, ext_re, ext_reg_en, ext_oe, ext_ack;
  logic [1:0]  ext_sel;
  logic [7:0]  ext_dout, ext_din;
  logic        uart_rx_valid, uart_busy, uart_send;
  logic [7:0]  uart_rx_data, uart_tx_data;

  ext_mem_bridge #(
    .ADDR_W(16), .DATA_W(16), .BUS_W(8), .WAIT_CYCLES(WAITC), .TIMEOUT(TMO),
    .UART_RX_ADDR(16'h7FA0), .UART_TX_ADDR(16'h7FA1), .UART_STAT_ADDR(16'h7FA2)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .ext_we(ext_we), .ext_re(ext_re), .ext_reg_en(ext_reg_en), .ext_sel(ext_sel),
    .ext_oe(ext_oe), .ext_dout(ext_dout), .ext_din(ext_din), .ext_ack(ext_ack),
    .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data), .uart_busy(uart_busy),
    .uart_send(uart_send), .uart_tx_data(uart_tx_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Response scoreboard
  typedef struct { logic [15:0] rdata; logic err; bit chk_rdata; } exp_t;
  exp_t sb[$];
  int   rsp_cnt = 0;

  always @(negedge clk) begin : sb_mon
    exp_t e;
    if (rsp_valid === 1'b1) begin
      rsp_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_rsp", 1, 0);
      end else begin
        e = sb.pop_front();
        check("rsp_error", rsp_error, e.err);
        if (e.chk_rdata) check("rsp_rdata", rsp_rdata, e.rdata);
      end
    end
  end

  // Bus trace and UART send monitor
  typedef struct { logic [7:0] dout; logic [1:0] sel; logic reg_en; logic we; logic re; } beat_t;
  beat_t      trace[$];
  int         ext_act = 0, send_cnt = 0, send_busy = 0, send_cyc = 0;
  logic [7:0] sent_byte = '0;

  always @(negedge clk) begin
    if (ext_oe === 1'b1) trace.push_back('{ext_dout, ext_sel, ext_reg_en, ext_we, ext_re});
    if (ext_we || ext_re || ext_reg_en || ext_oe || ext_sel != 0 || ext_dout != 0) ext_act++;
    if (uart_send === 1'b1) begin
      send_cnt++;
      sent_byte = uart_tx_data;
      send_cyc  = cyc;
      if (uart_busy) send_busy++;
    end
  end

  // Arduino read responder: data = captured address + 16'hAACD; ack high 2 cycles, low 1.
  logic [15:0] cap_addr = '0;
  logic [15:0] rv;
  int          ph = 0, rbeat = 0;
  logic        ack_dis = 1'b0;

  always @(negedge clk) begin
    if (ext_reg_en && ext_oe) begin
      if (ext_sel[0]) cap_addr[7:0] = ext_dout;
      else            cap_addr[15:8] = ext_dout;
    end
    if (ext_re && !ext_oe) begin
      rv = cap_addr + 16'hAACD;
      if (!ack_dis && (ph % 3) != 0) begin
        ext_ack = 1'b1;
        ext_din = (rbeat != 0) ? rv[15:8] : rv[7:0];
        if ((ph % 3) == 2) rbeat++;
      end else begin
        ext_ack = 1'b0;
        ext_din = 8'h5A;
      end
      ph++;
    end else begin
      ph = 0; rbeat = 0; ext_ack = 1'b0; ext_din = '0;
    end
  end

  int e0 = 0;

  task automatic do_req(input logic we, input logic [15:0] a, input logic [15:0] wd,
                        input exp_t e, output int lat);
    @(negedge clk);
    trace.delete();
    ext_act = 0; send_cnt = 0; send_busy = 0;
    sb.push_back(e);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
    e0 = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    check("req_ready_low", req_ready, 0);
    lat = -1;
    for (int i = 0; i < 400 && lat < 0; i++) begin
      if (rsp_valid === 1'b1) lat = cyc - e0;
      else @(negedge clk);
    end
    if (lat < 0) check("rsp_wait_expired", 1, 0);
    @(negedge clk);
    check("req_ready_high", req_ready, 1);
  endtask

  task automatic check_trace(input logic we, input logic [15:0] a, input logic [15:0] wd);
    int unsigned n, b, bi;
    int          bad;
    logic [7:0]  eb;
    logic [1:0]  es;
    n   = (we ? (AB + DB) : AB) * (WAITC + 1);
    bad = 0;
    check("trace_len", trace.size(), n);
    if (trace.size() == n) begin
      for (int unsigned k = 0; k < n; k++) begin
        b  = k / (WAITC + 1);
        bi = (b < AB) ? b : b - AB;
        eb = (b < AB) ? a[8*bi +: 8] : wd[8*bi +: 8];
        es = 2'b01 << bi;
        if (trace[k].dout !== eb || trace[k].sel !== es || trace[k].reg_en !== (b < AB) ||
            trace[k].we !== we || trace[k].re !== !we) bad++;
      end
    end
    check("trace_beats", bad, 0);
  endtask

  function automatic logic [63:0] out_vec();
    return {22'd0, req_ready, rsp_valid, rsp_error, ext_we, ext_re, ext_reg_en, ext_sel,
            ext_oe, ext_dout, uart_send, uart_tx_data, rsp_rdata};
  endfunction

  localparam logic [63:0] RESET_VEC = 64'h1 << 41;  // only req_ready high

  typedef struct {
    logic we; logic [15:0] addr; logic [15:0] wdata; logic [15:0] rdata;
    bit chk; int lat; bit ext; int sends;
  } vec_t;

  vec_t vt[9];
  int   lat, rc;

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1'b1, 16'h1234, 16'hBEEF, 16'h0000, 1'b0, 21, 1'b1, 0};
    vt[1] = '{1'b0, 16'h0100, 16'h0000, 16'hABCD, 1'b1, 16, 1'b1, 0};
    vt[2] = '{1'b0, 16'h2468, 16'h0000, 16'hCF35, 1'b1, 16, 1'b1, 0};
    vt[3] = '{1'b1, 16'h7FA1, 16'h0055, 16'h0000, 1'b0,  2, 1'b0, 1};
    vt[4] = '{1'b0, 16'h7FA2, 16'h0000, 16'h0000, 1'b1,  2, 1'b0, 0};
    vt[5] = '{1'b1, 16'h7FA0, 16'h1111, 16'h0000, 1'b1,  2, 1'b0, 0};
    vt[6] = '{1'b0, 16'h7FA1, 16'h0000, 16'h0000, 1'b1,  2, 1'b0, 0};
    vt[7] = '{1'b0, 16'hFFFF, 16'h0000, 16'hAACC, 1'b1, 16, 1'b1, 0};
    vt[8] = '{1'b1, 16'h00FF, 16'h5AA5, 16'h0000, 1'b0, 21, 1'b1, 0};

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    uart_rx_valid = 1'b0; uart_rx_data = '0; uart_busy = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", out_vec(), RESET_VEC);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      do_req(vt[i].we, vt[i].addr, vt[i].wdata, '{vt[i].rdata, 1'b0, vt[i].chk}, lat);
      check("latency", lat, vt[i].lat);
      if (vt[i].ext) check_trace(vt[i].we, vt[i].addr, vt[i].wdata);
      else           check("uart_no_ext", ext_act, 0);
      check("send_count", send_cnt, vt[i].sends);
      if (vt[i].sends != 0) check("tx_byte", sent_byte, vt[i].wdata[7:0]);
    end

    // Read timeout: no acknowledge at all
    ack_dis = 1'b1;
    do_req(1'b0, 16'h0200, 16'h0000, '{16'h0000, 1'b1, 1'b1}, lat);
    check("timeout_latency", lat, AB * (WAITC + 1) + 1 + TMO);
    check_trace(1'b0, 16'h0200, 16'h0000);
    ack_dis = 1'b0;

    // RX overflow, read and status clear
    @(negedge clk); uart_rx_valid = 1'b1; uart_rx_data = 8'h41;
    @(negedge clk); uart_rx_data = 8'h42;
    @(negedge clk); uart_rx_valid = 1'b0;
    do_req(1'b0, 16'h7FA2, 16'h0, '{16'h0006, 1'b0, 1'b1}, lat);
    do_req(1'b0, 16'h7FA0, 16'h0, '{16'h0042, 1'b0, 1'b1}, lat);
    check("rx_latency", lat, 2);
    do_req(1'b0, 16'h7FA2, 16'h0, '{16'h0000, 1'b0, 1'b1}, lat);

    // RX strobe coinciding with the RX-read clear
    @(negedge clk); uart_rx_valid = 1'b1; uart_rx_data = 8'h10;
    @(negedge clk); uart_rx_valid = 1'b0;
    sb.push_back('{16'h0010, 1'b0, 1'b1});
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h7FA0;
    @(negedge clk); req_valid = 1'b0; uart_rx_valid = 1'b1; uart_rx_data = 8'h20;
    @(negedge clk); uart_rx_valid = 1'b0;
    do_req(1'b0, 16'h7FA0, 16'h0, '{16'h0020, 1'b0, 1'b1}, lat);
    do_req(1'b0, 16'h7FA2, 16'h0, '{16'h0000, 1'b0, 1'b1}, lat);

    // TX write while the transmitter is busy
    @(posedge clk); #1 uart_busy = 1'b1;
    fork
      do_req(1'b1, 16'h7FA1, 16'h0055, '{16'h0000, 1'b0, 1'b0}, lat);
      begin repeat (12) @(posedge clk); #1 uart_busy = 1'b0; end
    join
    check("tx_send_while_busy", send_busy, 0);
    check("tx_send_count", send_cnt, 1);
    check("tx_byte_busy", sent_byte, 8'h55);
    check("tx_no_ext", ext_act, 0);
    check("tx_rsp_after_send", e0 + lat, send_cyc + 1);

    // Reset during the third write beat
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h1234; req_wdata = 16'hBEEF;
    @(negedge clk); req_valid = 1'b0;
    repeat (11) @(negedge clk);
    check("third_beat", {ext_we, ext_reg_en, ext_sel, ext_oe, ext_dout}, {1'b1, 1'b0, 2'b01, 1'b1, 8'hEF});
    rc = rsp_cnt;
    #1 reset = 1'b1;
    #1 check("mid_op_reset_outputs", out_vec(), RESET_VEC);
    @(negedge clk); reset = 1'b0;
    repeat (30) @(negedge clk);
    check("no_rsp_after_reset", rsp_cnt - rc, 0);
    do_req(1'b1, 16'h0ABC, 16'h1357, '{16'h0000, 1'b0, 1'b0}, lat);
    check("post_reset_latency", lat, 21);
    check_trace(1'b1, 16'h0ABC, 16'h1357);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
